// File: rtl/nand_bus_sequencer_pkg.sv
// Shared definitions for the NAND pin-interface sequencer: operation codes,
// FSM states and the registered pin bundle with its reset/idle value.
package nand_bus_sequencer_pkg;

    localparam int unsigned OP_W   = 3;
    localparam int unsigned BYTE_W = 8;

    // Operation codes presented on op_type; codes above OP_WAIT_RB are illegal.
    typedef enum logic [OP_W-1:0] {
        OP_CMD     = 3'd0,
        OP_ADDR    = 3'd1,
        OP_WRITE   = 3'd2,
        OP_READ    = 3'd3,
        OP_WAIT_RB = 3'd4
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_TWB,
        ST_POLL
    } state_e;

    // Everything that drives a NAND pad, held in one register.
    typedef struct packed {
        logic              nce;
        logic              cle;
        logic              ale;
        logic              nwe;
        logic              nre;
        logic              nwp;
        logic              io_oe;
        logic [BYTE_W-1:0] io_out;
    } pins_t;

    // Deselected, write-protected, strobes high, IO released.
    localparam pins_t PINS_RESET = '{
        nce:    1'b1,
        cle:    1'b0,
        ale:    1'b0,
        nwe:    1'b1,
        nre:    1'b1,
        nwp:    1'b0,
        io_oe:  1'b0,
        io_out: 8'h00
    };

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return op <= OP_WAIT_RB;
    endfunction

endpackage

// File: rtl/nand_bus_sequencer_rb_sync.sv
// Two-flop synchroniser for the asynchronous NAND R/nB pin.
// Ports: clk, rst_n (async active-low), async_in (raw R/nB),
//        sync_out (synchronised, resets to 0 = busy).
module nand_bus_sequencer_rb_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/nand_bus_sequencer.sv
// Cycle-level timing engine for the NAND flash pin interface. Runs one bus
// operation per accepted request: command latch, address latch, data write,
// data read or wait-for-ready.
// Ports:
//   PCLK, PRESETN          clock, async active-low reset
//   op_valid/op_ready      request handshake; op_type, op_data captured at accept
//   chip_en, wp_n_i        register bits driving nCE (inverted) and nWP
//   done, err, rd_data     completion pulse, error flag, last byte read
//   nCE CLE ALE nWE nRE nWP io_out io_oe   registered NAND pad outputs
//   io_in, RnB             IO pad input data, asynchronous ready/busy
module nand_bus_sequencer
    import nand_bus_sequencer_pkg::*;
#(
    parameter int unsigned TWP  = 2,
    parameter int unsigned TWH  = 2,
    parameter int unsigned TWB  = 4,
    parameter int unsigned TO_W = 16
) (
    input  logic        PCLK,
    input  logic        PRESETN,
    input  logic        op_valid,
    input  logic [2:0]  op_type,
    input  logic [7:0]  op_data,
    output logic        op_ready,
    input  logic        chip_en,
    input  logic        wp_n_i,
    output logic        done,
    output logic        err,
    output logic [7:0]  rd_data,
    output logic        nCE,
    output logic        CLE,
    output logic        ALE,
    output logic        nWE,
    output logic        nRE,
    output logic        nWP,
    output logic [7:0]  io_out,
    output logic        io_oe,
    input  logic [7:0]  io_in,
    input  logic        RnB
);

    // One counter serves SETUP/STROBE/HOLD/TWB, so size it for the longest phase.
    localparam int unsigned CNT_MAX = (TWP > TWH) ? ((TWP > TWB) ? TWP : TWB)
                                                  : ((TWH > TWB) ? TWH : TWB);
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TO_W-1:0]    to_q, to_d;
    op_e                op_q, op_d;
    pins_t              pins_q, pins_d;
    logic               op_ready_q, op_ready_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [BYTE_W-1:0]  rd_cap_q, rd_cap_d;
    logic [BYTE_W-1:0]  rd_data_q, rd_data_d;
    logic               rb_sync;

    nand_bus_sequencer_rb_sync u_rb_sync (
        .clk      (PCLK),
        .rst_n    (PRESETN),
        .async_in (RnB),
        .sync_out (rb_sync)
    );

    // State and output registers.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            to_q       <= '0;
            op_q       <= OP_CMD;
            pins_q     <= PINS_RESET;
            op_ready_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_cap_q   <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            to_q       <= to_d;
            op_q       <= op_d;
            pins_q     <= pins_d;
            op_ready_q <= op_ready_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rd_cap_q   <= rd_cap_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Next state and next registered outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        to_d      = to_q;
        op_d      = op_q;
        pins_d    = pins_q;
        pins_d.nce = ~chip_en;
        pins_d.nwp = wp_n_i;
        done_d    = 1'b0;
        err_d     = 1'b0;
        rd_cap_d  = rd_cap_q;
        rd_data_d = rd_data_q;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (op_valid && op_ready_q) begin
                    if (!chip_en || !op_is_legal(op_type)) begin
                        // Rejected without touching the bus.
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        op_d = op_e'(op_type);
                        if (op_type == OP_WAIT_RB) begin
                            state_d = ST_TWB;
                        end else begin
                            state_d    = ST_SETUP;
                            pins_d.cle = (op_type == OP_CMD);
                            pins_d.ale = (op_type == OP_ADDR);
                            if (op_type != OP_READ) begin
                                pins_d.io_oe  = 1'b1;
                                pins_d.io_out = op_data;
                            end
                        end
                    end
                end
            end

            ST_SETUP: begin
                state_d = ST_STROBE;
                cnt_d   = '0;
                if (op_q == OP_READ) pins_d.nre = 1'b0;
                else                 pins_d.nwe = 1'b0;
            end

            ST_STROBE: begin
                if (cnt_q == CNT_W'(TWP - 1)) begin
                    state_d    = ST_HOLD;
                    cnt_d      = '0;
                    pins_d.nwe = 1'b1;
                    pins_d.nre = 1'b1;
                    // Sample the pad on the last cycle nRE is low.
                    if (op_q == OP_READ) rd_cap_d = io_in;
                end
            end

            ST_HOLD: begin
                if (cnt_q == CNT_W'(TWH - 1)) begin
                    state_d      = ST_IDLE;
                    cnt_d        = '0;
                    pins_d.cle   = 1'b0;
                    pins_d.ale   = 1'b0;
                    pins_d.io_oe = 1'b0;
                    done_d       = 1'b1;
                    if (op_q == OP_READ) rd_data_d = rd_cap_q;
                end
            end

            ST_TWB: begin
                if (cnt_q == CNT_W'(TWB - 1)) begin
                    state_d = ST_POLL;
                    cnt_d   = '0;
                    to_d    = '0;
                end
            end

            ST_POLL: begin
                cnt_d = '0;
                if (rb_sync) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (to_q == {TO_W{1'b1}}) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        op_ready_d = (state_d == ST_IDLE);
    end

    assign op_ready = op_ready_q;
    assign done     = done_q;
    assign err      = err_q;
    assign rd_data  = rd_data_q;
    assign nCE      = pins_q.nce;
    assign CLE      = pins_q.cle;
    assign ALE      = pins_q.ale;
    assign nWE      = pins_q.nwe;
    assign nRE      = pins_q.nre;
    assign nWP      = pins_q.nwp;
    assign io_out   = pins_q.io_out;
    assign io_oe    = pins_q.io_oe;

endmodule

// File: tb/tb_nand_bus_sequencer.sv
// Directed bench for nand_bus_sequencer. Cycle k counts clock edges after the
// accepting edge; outputs are sampled on the falling edge of each cycle.
// A second instance with TO_W=4 exercises the ready/busy timeout.
module tb_nand_bus_sequencer;

    logic       PCLK = 1'b0;
    logic       PRESETN = 1'b0;
    logic       op_valid = 1'b0;
    logic       op_valid2 = 1'b0;
    logic [2:0] op_type = 3'd0;
    logic [7:0] op_data = 8'h00;
    logic       chip_en = 1'b1;
    logic       wp_n_i = 1'b1;
    logic [7:0] io_in = 8'hFF;
    logic       RnB = 1'b1;

    logic       op_ready, done, err, nCE, CLE, ALE, nWE, nRE, nWP, io_oe;
    logic [7:0] rd_data, io_out;

    logic       op_ready2, done2, err2, nCE2, CLE2, ALE2, nWE2, nRE2, nWP2, io_oe2;
    logic [7:0] rd_data2, io_out2;

    int n_tests = 0;
    int n_fail  = 0;
    int done_k;
    int done_cnt;

    always #5 PCLK = ~PCLK;

    nand_bus_sequencer dut (
        .PCLK(PCLK), .PRESETN(PRESETN), .op_valid(op_valid), .op_type(op_type),
        .op_data(op_data), .op_ready(op_ready), .chip_en(chip_en), .wp_n_i(wp_n_i),
        .done(done), .err(err), .rd_data(rd_data), .nCE(nCE), .CLE(CLE), .ALE(ALE),
        .nWE(nWE), .nRE(nRE), .nWP(nWP), .io_out(io_out), .io_oe(io_oe),
        .io_in(io_in), .RnB(RnB)
    );

    nand_bus_sequencer #(.TO_W(4)) dut_to (
        .PCLK(PCLK), .PRESETN(PRESETN), .op_valid(op_valid2), .op_type(op_type),
        .op_data(op_data), .op_ready(op_ready2), .chip_en(chip_en), .wp_n_i(wp_n_i),
        .done(done2), .err(err2), .rd_data(rd_data2), .nCE(nCE2), .CLE(CLE2), .ALE(ALE2),
        .nWE(nWE2), .nRE(nRE2), .nWP(nWP2), .io_out(io_out2), .io_oe(io_oe2),
        .io_in(io_in), .RnB(RnB)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        @(negedge PCLK);
    endtask

    // Reset image of the timeout instance:
    // {op_ready,done,err,rd_data,nCE,CLE,ALE,nWE,nRE,nWP,io_out,io_oe}
    function automatic logic [31:0] dut2_pins();
        return 32'({op_ready2, done2, err2, rd_data2, nCE2, CLE2, ALE2,
                    nWE2, nRE2, nWP2, io_out2, io_oe2});
    endfunction

    localparam logic [31:0] DUT2_RST = 32'({1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0,
                                            1'b1, 1'b1, 1'b0, 8'h00, 1'b0});

    initial begin
        // ---------------- reset values
        @(negedge PCLK);
        @(negedge PCLK);
        chk1("rst nCE", nCE, 1'b1);
        chk1("rst CLE", CLE, 1'b0);
        chk1("rst ALE", ALE, 1'b0);
        chk1("rst nWE", nWE, 1'b1);
        chk1("rst nRE", nRE, 1'b1);
        chk1("rst nWP", nWP, 1'b0);
        chk1("rst io_oe", io_oe, 1'b0);
        chk8("rst io_out", io_out, 8'h00);
        chk1("rst op_ready", op_ready, 1'b0);
        chk1("rst done", done, 1'b0);
        chk1("rst err", err, 1'b0);
        chk8("rst rd_data", rd_data, 8'h00);
        chk32("rst dut_to", dut2_pins(), DUT2_RST);

        PRESETN = 1'b1;
        step();
        chk1("post-rst op_ready", op_ready, 1'b1);
        chk1("post-rst nCE", nCE, 1'b0);
        chk1("post-rst nWP", nWP, 1'b1);

        // ---------------- CMD 0x70: SETUP 1, STROBE 2-3, HOLD 4-5, done 6
        op_type = 3'd0; op_data = 8'h70; op_valid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 1) op_valid = 1'b0;
            chk1($sformatf("cmd CLE k%0d", k), CLE, k <= 5);
            chk1($sformatf("cmd io_oe k%0d", k), io_oe, k <= 5);
            if (k <= 5) chk8($sformatf("cmd io_out k%0d", k), io_out, 8'h70);
            chk1($sformatf("cmd nWE k%0d", k), nWE, !(k == 2 || k == 3));
            chk1($sformatf("cmd done k%0d", k), done, k == 6);
            chk1($sformatf("cmd op_ready k%0d", k), op_ready, k == 6);
            chk1($sformatf("cmd err k%0d", k), err, 1'b0);
        end

        // ---------------- ADDR 0x12 then WRITE 0xA5 back-to-back
        // The WRITE request is presented while ADDR is busy and must be ignored until idle.
        op_type = 3'd1; op_data = 8'h12; op_valid = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 1) begin op_type = 3'd2; op_data = 8'hA5; end
            if (k == 7) op_valid = 1'b0;
            chk1($sformatf("aw ALE k%0d", k), ALE, k <= 5);
            chk1($sformatf("aw CLE k%0d", k), CLE, 1'b0);
            chk1($sformatf("aw io_oe k%0d", k), io_oe, (k <= 5) || (k >= 7 && k <= 11));
            if (k <= 5)             chk8($sformatf("aw io_out k%0d", k), io_out, 8'h12);
            if (k >= 7 && k <= 11)  chk8($sformatf("aw io_out k%0d", k), io_out, 8'hA5);
            chk1($sformatf("aw nWE k%0d", k), nWE, !(k == 2 || k == 3 || k == 8 || k == 9));
            chk1($sformatf("aw done k%0d", k), done, k == 6 || k == 12);
            chk1($sformatf("aw op_ready k%0d", k), op_ready, k == 6 || k == 12);
        end

        // ---------------- READ: io_in = 0x3C only around the last strobe cycle (3)
        op_type = 3'd3; op_valid = 1'b1; io_in = 8'hFF;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 1) begin op_valid = 1'b0; io_in = 8'h11; end
            if (k == 2) io_in = 8'h3C;
            if (k == 4) io_in = 8'hFF;
            chk1($sformatf("rd nRE k%0d", k), nRE, !(k == 2 || k == 3));
            chk1($sformatf("rd nWE k%0d", k), nWE, 1'b1);
            chk1($sformatf("rd io_oe k%0d", k), io_oe, 1'b0);
            chk1($sformatf("rd done k%0d", k), done, k == 6);
            chk8($sformatf("rd rd_data k%0d", k), rd_data, (k == 6) ? 8'h3C : 8'h00);
        end

        // ---------------- illegal op_type 6: done+err next cycle, no pin activity
        op_type = 3'd6; op_valid = 1'b1;
        step();
        op_valid = 1'b0;
        chk1("ill done", done, 1'b1);
        chk1("ill err", err, 1'b1);
        chk1("ill CLE", CLE, 1'b0);
        chk1("ill ALE", ALE, 1'b0);
        chk1("ill nWE", nWE, 1'b1);
        chk1("ill nRE", nRE, 1'b1);
        chk1("ill io_oe", io_oe, 1'b0);
        chk1("ill op_ready", op_ready, 1'b1);
        chk8("ill rd_data", rd_data, 8'h3C);
        step();
        chk1("ill done off", done, 1'b0);
        chk1("ill err off", err, 1'b0);

        // ---------------- chip_en = 0: CMD rejected
        op_type = 3'd0; op_data = 8'h55; chip_en = 1'b0; op_valid = 1'b1;
        step();
        op_valid = 1'b0;
        chk1("ce0 done", done, 1'b1);
        chk1("ce0 err", err, 1'b1);
        chk1("ce0 CLE", CLE, 1'b0);
        chk1("ce0 io_oe", io_oe, 1'b0);
        chk1("ce0 nCE", nCE, 1'b1);
        step();
        chk1("ce0 done off", done, 1'b0);
        chk1("ce0 nWE", nWE, 1'b1);
        chip_en = 1'b1;
        step();
        chk1("ce1 nCE", nCE, 1'b0);

        // ---------------- WAIT_RB: TWB cycles 1-4, POLL from 5; RnB rises mid cycle 20,
        // first sampled at the end of cycle 20, synchronised in cycle 22, done in cycle 23.
        RnB = 1'b0;
        step(); step(); step();
        op_type = 3'd4; op_valid = 1'b1;
        done_k = 0;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (k == 1) op_valid = 1'b0;
            if (k == 10)
                chk32("wrb pins quiet", 32'({CLE, ALE, nWE, nRE, io_oe}), 32'(5'b00110));
            if (done) begin
                done_k = k;
                break;
            end
            if (k == 20) RnB = 1'b1;
        end
        chk32("wrb done cycle", 32'(done_k), 32'd23);
        chk1("wrb err", err, 1'b0);
        chk1("wrb op_ready", op_ready, 1'b1);

        // ---------------- timeout on TO_W=4 instance: POLL cycles 5..20, done+err in 21
        RnB = 1'b0;
        step(); step(); step();
        chk1("to op_ready", op_ready2, 1'b1);
        op_type = 3'd4; op_valid2 = 1'b1;
        done_k = 0;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (k == 1) op_valid2 = 1'b0;
            if (done2) begin
                done_k = k;
                break;
            end
        end
        chk32("to done cycle", 32'(done_k), 32'd21);
        chk1("to err", err2, 1'b1);
        RnB = 1'b1;

        // ---------------- reset during STROBE aborts the CMD with no done
        op_type = 3'd0; op_data = 8'h70; op_valid = 1'b1;
        step();
        op_valid = 1'b0;
        step();
        chk1("arst pre nWE", nWE, 1'b0);
        #2 PRESETN = 1'b0;
        #1;
        chk1("arst nWE", nWE, 1'b1);
        chk1("arst CLE", CLE, 1'b0);
        chk1("arst io_oe", io_oe, 1'b0);
        chk1("arst nWP", nWP, 1'b0);
        chk1("arst nCE", nCE, 1'b1);
        chk1("arst done", done, 1'b0);
        chk1("arst op_ready", op_ready, 1'b0);
        chk32("arst dut_to", dut2_pins(), DUT2_RST);
        @(negedge PCLK);
        PRESETN = 1'b1;
        done_cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (done) done_cnt++;
        end
        chk32("arst no done", 32'(done_cnt), 32'd0);
        chk1("arst op_ready after", op_ready, 1'b1);
        chk1("arst CLE after", CLE, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of stimulus, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
